// File: rtl/pc_src_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_src_sequencer
// Purpose : Multicycle sequencer driving the PC-source mux select and the
//           PC/EPC write enables once per decoded instruction. Handles memory
//           wait stalls, exception entry, a retired-update counter and a
//           sticky stall-timeout flag.
// Revision: 1.0 - initial release
// ============================================================================
module pc_src_sequencer #(
  parameter int COUNT_W     = 16,
  parameter int STALL_LIMIT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [1:0]         instr_class,
  input  logic               branch_taken,
  input  logic               exc_req,
  input  logic               exc_code,
  input  logic               mem_wait,
  output logic [2:0]         pc_sel,
  output logic               pc_write,
  output logic               epc_write,
  output logic               cause,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] retired,
  output logic               stall_timeout
);

  // Stall counter only needs to reach STALL_LIMIT, where it saturates.
  localparam int                   C_STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [C_STALL_W-1:0] C_STALL_MAX = C_STALL_W'(STALL_LIMIT);
  localparam logic [C_STALL_W-1:0] C_STALL_PRE = C_STALL_W'(STALL_LIMIT - 1);
  localparam logic [C_STALL_W-1:0] C_STALL_ONE = C_STALL_W'(1);
  localparam logic [COUNT_W-1:0]   C_RET_ONE   = COUNT_W'(1);

  localparam logic [2:0] C_SEL_SEQ = 3'b000;
  localparam logic [2:0] C_SEL_REG = 3'b001;
  localparam logic [2:0] C_SEL_BR  = 3'b010;
  localparam logic [2:0] C_SEL_JMP = 3'b011;
  localparam logic [2:0] C_SEL_EXC = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EVAL     = 3'd1,
    S_UPDATE   = 3'd2,
    S_EXC_SAVE = 3'd3,
    S_EXC_VEC  = 3'd4
  } state_t;

  state_t               r_state;
  logic [1:0]           r_class;
  logic [C_STALL_W-1:0] r_stall_cnt;
  logic [2:0]           r_pc_sel;
  logic                 r_pc_write;
  logic                 r_epc_write;
  logic                 r_cause;
  logic                 r_done;
  logic [COUNT_W-1:0]   r_retired;
  logic                 r_stall_timeout;
  logic [2:0]           w_target;

  // Target select for a non-excepting instruction, from the latched class.
  always_comb begin
    w_target = C_SEL_SEQ;
    case (r_class)
      2'b00:   w_target = C_SEL_SEQ;
      2'b01:   w_target = branch_taken ? C_SEL_BR : C_SEL_SEQ;
      2'b10:   w_target = C_SEL_JMP;
      default: w_target = C_SEL_REG;
    endcase
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_class         <= 2'b00;
      r_stall_cnt     <= '0;
      r_pc_sel        <= C_SEL_SEQ;
      r_pc_write      <= 1'b0;
      r_epc_write     <= 1'b0;
      r_cause         <= 1'b0;
      r_done          <= 1'b0;
      r_retired       <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_class <= instr_class;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          // Exception wins over any PC target.
          if (exc_req) begin
            r_cause     <= exc_code;
            r_epc_write <= 1'b1;
            r_state     <= S_EXC_SAVE;
          end else begin
            r_pc_sel    <= w_target;
            r_pc_write  <= 1'b1;
            r_stall_cnt <= '0;
            r_state     <= S_UPDATE;
          end
        end
        S_EXC_SAVE: begin
          // EPC capture takes exactly one cycle regardless of mem_wait.
          r_epc_write <= 1'b0;
          r_pc_sel    <= C_SEL_EXC;
          r_pc_write  <= 1'b1;
          r_stall_cnt <= '0;
          r_state     <= S_EXC_VEC;
        end
        S_UPDATE, S_EXC_VEC: begin
          if (mem_wait) begin
            // Keep waiting; the timeout flag is only a report, not an abort.
            if (r_stall_cnt != C_STALL_MAX) begin
              r_stall_cnt <= r_stall_cnt + C_STALL_ONE;
            end
            if (r_stall_cnt >= C_STALL_PRE) begin
              r_stall_timeout <= 1'b1;
            end
          end else begin
            r_pc_write <= 1'b0;
            r_done     <= 1'b1;
            r_retired  <= r_retired + C_RET_ONE;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_sel        = r_pc_sel;
  assign pc_write      = r_pc_write;
  assign epc_write     = r_epc_write;
  assign cause         = r_cause;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign retired       = r_retired;
  assign stall_timeout = r_stall_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pc_src_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_src_sequencer
// Purpose : Self-checking bench for pc_src_sequencer. A transaction-level
//           model predicts the per-cycle output trace of each instruction.
//           A second instance with a 4-bit counter exercises the wrap.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_src_sequencer;

  localparam int LIMIT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [1:0]  instr_class = 2'b00;
  logic        branch_taken = 1'b0;
  logic        exc_req = 1'b0;
  logic        exc_code = 1'b0;
  logic        mem_wait = 1'b0;

  logic [2:0]  pc_sel;
  logic        pc_write, epc_write, cause, busy, done, stall_timeout;
  logic [15:0] retired;

  logic [2:0]  n_pc_sel;
  logic        n_pc_write, n_epc_write, n_cause, n_busy, n_done, n_stall_timeout;
  logic [3:0]  n_retired;

  logic [6:0]  obs;
  logic [6:0]  n_obs;
  assign obs   = {pc_sel, pc_write, epc_write, busy, done};
  assign n_obs = {n_pc_sel, n_pc_write, n_epc_write, n_busy, n_done};

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [2:0]  m_sel     = 3'b000;
  logic        m_cause   = 1'b0;
  logic        m_timeout = 1'b0;
  logic [31:0] m_retired = 32'd0;

  pc_src_sequencer #(.COUNT_W(16), .STALL_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instr_class(instr_class), .branch_taken(branch_taken), .exc_req(exc_req),
    .exc_code(exc_code), .mem_wait(mem_wait), .pc_sel(pc_sel),
    .pc_write(pc_write), .epc_write(epc_write), .cause(cause), .busy(busy),
    .done(done), .retired(retired), .stall_timeout(stall_timeout)
  );

  pc_src_sequencer #(.COUNT_W(4), .STALL_LIMIT(LIMIT)) dut_n (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instr_class(instr_class), .branch_taken(branch_taken), .exc_req(exc_req),
    .exc_code(exc_code), .mem_wait(mem_wait), .pc_sel(n_pc_sel),
    .pc_write(n_pc_write), .epc_write(n_epc_write), .cause(n_cause), .busy(n_busy),
    .done(n_done), .retired(n_retired), .stall_timeout(n_stall_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2:0] target_of(input logic [1:0] cls, input logic br);
    case (cls)
      2'b00:   return 3'b000;
      2'b01:   return br ? 3'b010 : 3'b000;
      2'b10:   return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  // One instruction from a negedge in IDLE to the negedge of its done cycle.
  task automatic run_instr(input logic [1:0] cls, input logic br, input logic exc,
                           input logic code, input int nstall, input logic poke);
    logic [2:0]  tgt;
    logic [7:0]  e8;
    logic [31:0] act;
    logic [31:0] exp;
    // cycle N
    instr_valid = 1'b1; instr_class = cls;
    branch_taken = 1'($urandom); exc_req = 1'($urandom);
    exc_code = 1'($urandom); mem_wait = 1'($urandom);
    @(negedge clock);
    // cycle N+1: EVAL
    e8 = {m_sel, 1'b0, 1'b0, 1'b1, 1'b0, m_cause};
    n_chk++;
    if ({obs, cause} !== e8) $display("FAIL eval: got %h want %h", {obs, cause}, e8);
    else n_pass++;
    instr_valid = poke; instr_class = 2'($urandom);
    branch_taken = br; exc_req = exc; exc_code = code; mem_wait = 1'($urandom);
    @(negedge clock);
    branch_taken = 1'($urandom); exc_req = 1'($urandom); exc_code = 1'($urandom);
    if (exc) begin
      m_cause = code;
      e8 = {m_sel, 1'b0, 1'b1, 1'b1, 1'b0, m_cause};
      n_chk++;
      if ({obs, cause} !== e8) $display("FAIL exc_save: got %h want %h", {obs, cause}, e8);
      else n_pass++;
      mem_wait = 1'($urandom); instr_valid = poke;
      @(negedge clock);
      tgt = 3'b100;
    end else begin
      tgt = target_of(cls, br);
    end
    m_sel = tgt;
    for (int s = 0; s <= nstall; s++) begin
      e8 = {tgt, 1'b1, 1'b0, 1'b1, 1'b0, (m_timeout || (s >= LIMIT))};
      n_chk++;
      if ({obs, stall_timeout} !== e8)
        $display("FAIL write[%0d]: got %h want %h", s, {obs, stall_timeout}, e8);
      else n_pass++;
      mem_wait = (s < nstall); instr_valid = (s == 0) ? poke : 1'b0;
      branch_taken = 1'($urandom); exc_req = 1'($urandom);
      @(negedge clock);
    end
    if (nstall >= LIMIT) m_timeout = 1'b1;
    m_retired = m_retired + 32'd1;
    // done cycle
    act = {obs, n_obs, stall_timeout, n_stall_timeout, cause, n_cause, retired};
    exp = {m_sel, 4'b0001, m_sel, 4'b0001, m_timeout, m_timeout, m_cause, m_cause,
           m_retired[15:0]};
    n_chk++;
    if (act !== exp) $display("FAIL done: got %h want %h", act, exp);
    else n_pass++;
    n_chk++;
    if (n_retired !== m_retired[3:0])
      $display("FAIL retired_narrow: got %0d want %0d", n_retired, m_retired[3:0]);
    else n_pass++;
    instr_valid = 1'b0; mem_wait = 1'b0;
  endtask

  // Idle cycles with junk on the inputs that only matter in EVAL.
  task automatic idle_cycles(input int n);
    logic [22:0] act;
    logic [22:0] exp;
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0; branch_taken = 1'($urandom);
      exc_req = 1'($urandom); mem_wait = 1'($urandom);
      @(negedge clock);
      act = {obs, retired};
      exp = {m_sel, 4'b0000, m_retired[15:0]};
      n_chk++;
      if (act !== exp) $display("FAIL idle: got %h want %h", act, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    logic [29:0] act;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    act = {obs, stall_timeout, cause, retired, n_retired};
    n_chk++;
    if (act !== 30'h0) $display("FAIL reset: got %h want 0", act);
    else n_pass++;
    reset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_sequential;
    run_instr(2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_branch_jump;
    run_instr(2'b01, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_instr(2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(2'b11, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_exception;
    run_instr(2'b10, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    run_instr(2'b00, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_stall_clear;
    run_instr(2'b00, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    run_instr(2'b01, 1'b1, 1'b1, 1'b0, 10, 1'b0);
    run_instr(2'b10, 1'b0, 1'b0, 1'b0, 10, 1'b0);
  endtask

  task automatic test_timeout;
    run_instr(2'b00, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    run_instr(2'b11, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_ignore;
    run_instr(2'b01, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle_cycles(2);
    run_instr(2'b11, 1'b0, 1'b1, 1'b1, 2, 1'b1);
    idle_cycles(2);
  endtask

  task automatic test_reset_mid;
    logic [30:0] act;
    instr_valid = 1'b1; instr_class = 2'b10;
    @(negedge clock);
    instr_valid = 1'b0; exc_req = 1'b0;
    @(negedge clock);
    n_chk++;
    if (obs !== 7'b011_1_0_1_0) $display("FAIL reset_mid_update: got %b want 0111010", obs);
    else n_pass++;
    mem_wait = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    act = {obs, stall_timeout, cause, retired, n_retired, n_pc_write};
    n_chk++;
    if (act !== 31'h0) $display("FAIL reset_mid: got %h want 0", act);
    else n_pass++;
    m_sel = 3'b000; m_cause = 1'b0; m_timeout = 1'b0; m_retired = 32'd0;
    @(negedge clock);
    reset = 1'b0; mem_wait = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 16; i++) begin
      run_instr(2'($urandom), 1'($urandom), 1'b0, 1'b0, 0, 1'b0);
    end
    n_chk++;
    if (n_retired !== 4'd0 || retired !== 16'd16)
      $display("FAIL wrap: got %0d/%0d want 0/16", n_retired, retired);
    else n_pass++;
  endtask

  task automatic test_random;
    int ns;
    for (int i = 0; i < 40; i++) begin
      ns = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 18))
                                       : int'($urandom_range(0, 3));
      run_instr(2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                1'($urandom), ns, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jump();
    test_exception();
    test_stall_clear();
    test_timeout();
    test_ignore();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
